sram_write_arbiter: RTL

Merges the two SRAM write streams (W0: image buffer writer, W1: overlay writer) into one registered ready/valid stream of {mask,addr,data} words for the SRAM arbiter's write port. Grants are held for bounded bursts so that a long background frame write cannot starve overlay updates. A strict-priority mode is available for frames where the background must not be interleaved. All logic is on the single SRAM-side clock; both writers must already be synchronous to it.

---
 rtl/sram_write_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_write_arbiter.sv
// Two-writer SRAM write-stream arbiter with bounded bursts, optional strict W0
// priority, a one-entry registered output stage and per-writer beat counters.
//
// state | meaning
// IDLE  | no owner; arbitrating, no readies asserted
// GNT0  | writer 0 owns the output stage
// GNT1  | writer 1 owns the output stage
module sram_write_arbiter #(
    parameter int DATA_WIDTH = 54,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] w0_din,
    input  logic                  w0_valid,
    output logic                  w0_ready,
    input  logic [DATA_WIDTH-1:0] w1_din,
    input  logic                  w1_valid,
    output logic                  w1_ready,
    input  logic                  priority_w0,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  w0_beats,
    output logic [CNT_WIDTH-1:0]  w1_beats,
    input  logic                  clear_counts
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             state;
    state_t             arb_pick;
    logic [1:0]         arb_grant;
    logic               rr_last;
    logic [BURST_W-1:0] burst_cnt;
    logic               load;
    logic               beat0;
    logic               beat1;
    logic               beat;
    logic               cur_valid;
    logic               release_gnt;
    logic               arb_last;

    assign load     = ~dout_valid | dout_ready;
    assign w0_ready = (state == GNT0) & load;
    assign w1_ready = (state == GNT1) & load;
    assign beat0    = w0_valid & w0_ready;
    assign beat1    = w1_valid & w1_ready;
    assign beat     = beat0 | beat1;

    assign cur_valid   = (state == GNT1) ? w1_valid : w0_valid;
    assign release_gnt = (state != IDLE) &
                         (~cur_valid | (beat & (burst_cnt == BURST_LAST)));

    // At a release the outgoing owner becomes the round-robin "last" at once,
    // so the same-cycle re-arbitration already sees the updated history.
    assign arb_last = (state == IDLE) ? rr_last : (state == GNT1);

    always_comb begin
        arb_pick = IDLE;
        if (w0_valid & ~w1_valid) begin
            arb_pick = GNT0;
        end else if (w1_valid & ~w0_valid) begin
            arb_pick = GNT1;
        end else if (w0_valid & w1_valid) begin
            arb_pick = (priority_w0 | arb_last) ? GNT0 : GNT1;
        end
        arb_grant = {arb_pick == GNT1, arb_pick == GNT0};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            rr_last    <= 1'b1;
            burst_cnt  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            w0_beats   <= '0;
            w1_beats   <= '0;
        end else begin
            if (state == IDLE) begin
                state <= arb_pick;
                grant <= arb_grant;
            end else if (release_gnt) begin
                rr_last   <= (state == GNT1);
                burst_cnt <= '0;
                state     <= arb_pick;
                grant     <= arb_grant;
            end else if (beat) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end

            if (beat) begin
                dout       <= beat1 ? w1_din : w0_din;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (clear_counts) begin
                w0_beats <= '0;
                w1_beats <= '0;
            end else begin
                if (beat0) w0_beats <= w0_beats + CNT_WIDTH'(1);
                if (beat1) w1_beats <= w1_beats + CNT_WIDTH'(1);
            end
        end
    end

endmodule
